// File: rtl/fsab_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : fsab_sram_responder
// Brief    : FSAB target: credit-managed request FIFO feeding a 64-bit RAM.
//            Optional macro FSAB_RESP_ERRCHK_EN enables the sticky err checker.
// Revision : 1.0 - initial release
// ============================================================================
module fsab_sram_responder #(
    parameter int FIFO_DEPTH = 8,
    parameter int MEM_AW     = 10,
    parameter int LEN_W      = 3,
    parameter int DID_W      = 4,
    parameter int ADDR_W     = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fsabo_valid,
    input  logic              fsabo_mode,
    input  logic [DID_W-1:0]  fsabo_did,
    input  logic [DID_W-1:0]  fsabo_subdid,
    input  logic [ADDR_W-1:0] fsabo_addr,
    input  logic [LEN_W-1:0]  fsabo_len,
    input  logic [63:0]       fsabo_data,
    input  logic [7:0]        fsabo_mask,
    output logic              fsabo_credit,
    output logic              fsabi_valid,
    output logic [DID_W-1:0]  fsabi_did,
    output logic [DID_W-1:0]  fsabi_subdid,
    output logic [63:0]       fsabi_data,
    output logic              err
);

    localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W  = C_PTR_W + 1;
    localparam int C_LOW_AW = MEM_AW + 3;

    typedef struct packed {
        logic                mode;
        logic [DID_W-1:0]    did;
        logic [DID_W-1:0]    subdid;
        logic [C_LOW_AW-1:0] addr;
        logic [LEN_W-1:0]    len;
        logic [63:0]         data;
        logic [7:0]          mask;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WDATA = 2'd1,
        S_READ  = 2'd2
    } state_t;

    entry_t             r_fifo [FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;
    state_t             r_state;
    logic [MEM_AW-1:0]  r_addr;
    logic [LEN_W-1:0]   r_beats;
    logic [63:0]        r_mem [2**MEM_AW];

    entry_t             w_push_entry;
    entry_t             w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_we;
    logic [MEM_AW-1:0]  w_head_word;
    logic [MEM_AW-1:0]  w_waddr;
    logic [LEN_W-1:0]   w_head_len;
    logic               w_unused;

    assign w_push_entry = '{mode:   fsabo_mode,
                            did:    fsabo_did,
                            subdid: fsabo_subdid,
                            addr:   fsabo_addr[C_LOW_AW-1:0],
                            len:    fsabo_len,
                            data:   fsabo_data,
                            mask:   fsabo_mask};

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_full      = (r_count == C_CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    // READ never pops: only the read header itself consumed a credit
    assign w_pop       = !rst && !w_empty && (r_state != S_READ);
    assign w_push      = !rst && fsabo_valid && (!w_full || w_pop);
    assign fsabo_credit = w_pop;

    assign w_head_word = w_head.addr[C_LOW_AW-1:3];
    assign w_head_len  = (w_head.len == '0) ? LEN_W'(1) : w_head.len;
    assign w_we        = w_pop && ((r_state == S_WDATA) || w_head.mode);
    assign w_waddr     = (r_state == S_WDATA) ? r_addr : w_head_word;
    assign w_unused    = ^{fsabo_addr[ADDR_W-1:C_LOW_AW], w_head.addr[2:0]};

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 8; i++) begin
                if (w_head.mask[i]) begin
                    r_mem[w_waddr][8*i +: 8] <= w_head.data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_beats      <= '0;
            fsabi_valid  <= 1'b0;
            fsabi_did    <= '0;
            fsabi_subdid <= '0;
            fsabi_data   <= '0;
        end else begin
            fsabi_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head.mode) begin
                            r_addr  <= w_head_word + MEM_AW'(1);
                            r_beats <= w_head_len - LEN_W'(1);
                            if (w_head_len != LEN_W'(1)) begin
                                r_state <= S_WDATA;
                            end
                        end else begin
                            // previous read's last beat is already in the output regs
                            r_addr       <= w_head_word;
                            r_beats      <= w_head_len;
                            fsabi_did    <= w_head.did;
                            fsabi_subdid <= w_head.subdid;
                            r_state      <= S_READ;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_pop) begin
                        r_addr  <= r_addr + MEM_AW'(1);
                        r_beats <= r_beats - LEN_W'(1);
                        if (r_beats == LEN_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_READ: begin
                    fsabi_valid <= 1'b1;
                    fsabi_data  <= r_mem[r_addr];
                    r_addr      <= r_addr + MEM_AW'(1);
                    r_beats     <= r_beats - LEN_W'(1);
                    if (r_beats == LEN_W'(1)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FSAB_RESP_ERRCHK_EN
    logic r_err;
    logic w_overflow;
    logic w_hdr_pop;
    logic w_bad_len;
    logic w_bad_align;

    assign w_overflow  = !rst && fsabo_valid && w_full && !w_pop;
    assign w_hdr_pop   = w_pop && (r_state == S_IDLE);
    assign w_bad_len   = w_hdr_pop && (w_head.len == '0);
    assign w_bad_align = w_hdr_pop && (w_head.addr[2:0] != 3'd0);
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            if (w_overflow || w_bad_len || w_bad_align) begin
                r_err <= 1'b1;
            end
            if (w_overflow)  $display("fsab_sram_responder: warning: push while full, beat dropped");
            if (w_bad_len)   $display("fsab_sram_responder: warning: header with len 0");
            if (w_bad_align) $display("fsab_sram_responder: warning: header addr not 8-byte aligned");
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsab_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsab_sram_responder
// Brief    : Self-checking bench for fsab_sram_responder against a word-array
//            memory model and an expected-response queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsab_sram_responder;

    localparam int C_WORDS = 1024;
`ifdef FSAB_RESP_ERRCHK_EN
    localparam logic C_ERR_EXP = 1'b1;
`else
    localparam logic C_ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fsabo_valid = 1'b0;
    logic        fsabo_mode = 1'b0;
    logic [3:0]  fsabo_did = '0;
    logic [3:0]  fsabo_subdid = '0;
    logic [30:0] fsabo_addr = '0;
    logic [2:0]  fsabo_len = '0;
    logic [63:0] fsabo_data = '0;
    logic [7:0]  fsabo_mask = '0;
    logic        fsabo_credit;
    logic        fsabi_valid;
    logic [3:0]  fsabi_did;
    logic [3:0]  fsabi_subdid;
    logic [63:0] fsabi_data;
    logic        err;

    always #5 clk = ~clk;

    fsab_sram_responder dut (
        .clk          (clk),
        .rst          (rst),
        .fsabo_valid  (fsabo_valid),
        .fsabo_mode   (fsabo_mode),
        .fsabo_did    (fsabo_did),
        .fsabo_subdid (fsabo_subdid),
        .fsabo_addr   (fsabo_addr),
        .fsabo_len    (fsabo_len),
        .fsabo_data   (fsabo_data),
        .fsabo_mask   (fsabo_mask),
        .fsabo_credit (fsabo_credit),
        .fsabi_valid  (fsabi_valid),
        .fsabi_did    (fsabi_did),
        .fsabi_subdid (fsabi_subdid),
        .fsabi_data   (fsabi_data),
        .err          (err)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  did;
        logic [3:0]  sub;
    } rsp_t;

    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          credits = 8;
    int          cred_total = 0;
    int          cred_cyc = -1;
    int          vstart_cyc = -1;
    int          run = 0;
    int          last_run = 0;
    logic        prev_valid = 1'b0;
    logic        raw = 1'b0;
    logic [63:0] mdl [C_WORDS];
    logic [63:0] wd [8];
    logic [7:0]  wm [8];
    rsp_t        exp_q [$];
    rsp_t        mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (fsabo_credit) begin
                credits++;
                cred_total++;
                cred_cyc = cyc;
            end
            if (fsabi_valid) begin
                if (!prev_valid) vstart_cyc = cyc;
                run++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_data", fsabi_data, mon_e.data);
                    check("rsp_ids", {56'd0, fsabi_did, fsabi_subdid}, {56'd0, mon_e.did, mon_e.sub});
                end
            end else if (run > 0) begin
                last_run = run;
                run = 0;
            end
        end
        prev_valid = fsabi_valid && !rst;
    end

    task automatic send_beat(input logic mode, input logic [3:0] did, input logic [3:0] sub,
                             input int word, input int len, input logic [63:0] data,
                             input logic [7:0] mask);
        int guard = 0;
        while (!raw && credits <= 0 && guard < 1000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 1000) check("credit_timeout", 64'd0, 64'd1);
        fsabo_valid  = 1'b1;
        fsabo_mode   = mode;
        fsabo_did    = did;
        fsabo_subdid = sub;
        fsabo_addr   = 31'(word) << 3;
        fsabo_len    = 3'(len);
        fsabo_data   = data;
        fsabo_mask   = mask;
        credits--;
        @(posedge clk); #1;
        fsabo_valid  = 1'b0;
    endtask

    task automatic send_write(input int word, input int len, input logic [3:0] did);
        int l = (len == 0) ? 1 : len;
        for (int k = 0; k < l; k++) begin
            int w = (word + k) % C_WORDS;
            send_beat(1'b1, did, 4'd0, word, len, wd[k], wm[k]);
            for (int b = 0; b < 8; b++)
                if (wm[k][b]) mdl[w][8*b +: 8] = wd[k][8*b +: 8];
        end
    endtask

    task automatic send_read(input int word, input int len, input logic [3:0] did, input logic [3:0] sub);
        int l = (len == 0) ? 1 : len;
        rsp_t e;
        send_beat(1'b0, did, sub, word, len, 64'd0, 8'd0);
        for (int k = 0; k < l; k++) begin
            e.data = mdl[(word + k) % C_WORDS];
            e.did  = did;
            e.sub  = sub;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int cred_target);
        int g = 0;
        while ((exp_q.size() != 0 || credits != cred_target || fsabi_valid) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) check("drain_timeout", 64'd0, 64'd1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic rand_burst(input int len, input logic [7:0] fixed_mask, input logic use_fixed);
        for (int k = 0; k < 8; k++) begin
            wd[k] = {$urandom, $urandom};
            wm[k] = use_fixed ? fixed_mask : 8'($urandom);
        end
        if (len < 0) wd[0] = wd[0];
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int seen;
        int g;
        int bad;

        // reset state
        repeat (3) begin @(posedge clk); #1; end
        check("rst_valid",  {63'd0, fsabi_valid},  64'd0);
        check("rst_credit", {63'd0, fsabo_credit}, 64'd0);
        check("rst_err",    {63'd0, err},          64'd0);
        check("rst_data",   fsabi_data,            64'd0);
        rst = 1'b0;

        // give every RAM word a known value
        for (int w = 0; w < C_WORDS; w += 7) begin
            rand_burst(7, 8'hFF, 1'b1);
            send_write(w, (C_WORDS - w < 7) ? C_WORDS - w : 7, 4'd1);
        end
        drain(8);

        // single write then read, latency from read pop to first beat
        wd[0] = 64'h1122334455667788; wm[0] = 8'hFF;
        c0 = cred_total;
        send_write(8, 1, 4'd3);
        send_read(8, 1, 4'd3, 4'd5);
        drain(8);
        check("single_credits", 64'(cred_total - c0), 64'd2);
        check("read_latency", 64'(vstart_cyc - cred_cyc), 64'd2);

        // burst with partial mask on beat 2
        for (int k = 0; k < 4; k++) begin
            wd[k] = 64'hA0 + 64'(k);
            wm[k] = (k == 2) ? 8'h0F : 8'hFF;
        end
        c0 = cred_total;
        send_write(8, 4, 4'd2);
        drain(8);
        check("burst_write_credits", 64'(cred_total - c0), 64'd4);
        check("burst_beat2_model", mdl[10][31:0], 64'hA2);
        send_read(8, 4, 4'd1, 4'd2);
        drain(8);
        check("burst_contiguous", 64'(last_run), 64'd4);

        // wrap from top word to word 0
        rand_burst(2, 8'hFF, 1'b1);
        send_write(C_WORDS - 1, 2, 4'd4);
        send_read(C_WORDS - 1, 2, 4'd6, 4'd9);
        drain(8);
        check("wrap_run", 64'(last_run), 64'd2);

        // eight write beats queued behind a long read
        c0 = cred_total;
        send_read(100, 7, 4'd2, 4'd2);
        rand_burst(7, 8'hFF, 1'b1);
        send_write(200, 7, 4'd5);
        rand_burst(1, 8'hFF, 1'b1);
        send_write(300, 1, 4'd5);
        drain(8);
        check("stall_credits", 64'(cred_total - c0), 64'd9);
        check("stall_err", {63'd0, err}, 64'd0);
        send_read(200, 7, 4'd8, 4'd1);
        send_read(300, 1, 4'd8, 4'd2);
        drain(8);

        // len 0 header runs as exactly one beat
        rand_burst(1, 8'hFF, 1'b1);
        send_write(400, 0, 4'd3);
        rand_burst(1, 8'hFF, 1'b1);
        send_write(401, 1, 4'd3);
        send_read(400, 0, 4'd4, 4'd4);
        send_read(400, 2, 4'd4, 4'd5);
        drain(8);
        check("len0_err", {63'd0, err}, {63'd0, C_ERR_EXP});

        // overflow: 11 back-to-back beats, the 11th arrives full with no pop
        c0 = cred_total;
        raw = 1'b1;
        send_read(500, 7, 4'd1, 4'd1);
        send_read(510, 7, 4'd1, 4'd2);
        rand_burst(7, 8'hFF, 1'b1);
        send_write(520, 7, 4'd2);
        rand_burst(1, 8'hFF, 1'b1);
        send_write(530, 1, 4'd2);
        send_beat(1'b1, 4'd2, 4'd0, 540, 1, ~mdl[540], 8'hFF);
        raw = 1'b0;
        drain(7);
        credits = 8;
        check("ovf_credits", 64'(cred_total - c0), 64'd10);
        check("ovf_err", {63'd0, err}, {63'd0, C_ERR_EXP});
        send_read(540, 1, 4'd7, 4'd7);
        send_read(520, 7, 4'd7, 4'd8);
        send_read(530, 1, 4'd7, 4'd9);
        drain(8);

        // randomized mix of reads and writes
        for (int n = 0; n < 40; n++) begin
            int word = $urandom_range(0, C_WORDS - 1);
            int len  = $urandom_range(1, 7);
            if ($urandom_range(0, 1) == 1) begin
                rand_burst(len, 8'h00, 1'b0);
                send_write(word, len, 4'($urandom));
            end else begin
                send_read(word, len, 4'($urandom), 4'($urandom));
            end
        end
        drain(8);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        // reset during beat 2 of a 4-beat read
        send_read(8, 4, 4'd7, 4'd7);
        seen = 0;
        g = 0;
        while (seen < 2 && g < 50) begin
            @(posedge clk); #1;
            if (fsabi_valid) seen++;
            g++;
        end
        if (g >= 50) check("midrst_timeout", 64'd0, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid",  {63'd0, fsabi_valid},  64'd0);
        check("midrst_credit", {63'd0, fsabo_credit}, 64'd0);
        rst = 1'b0;
        exp_q.delete();
        credits = 8;
        run = 0;
        bad = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (fsabi_valid || fsabo_credit) bad++;
        end
        check("midrst_quiet", 64'(bad), 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        check("midrst_credits", 64'(credits), 64'd8);
        send_read(8, 4, 4'd2, 4'd3);
        drain(8);
        check("midrst_after_run", 64'(last_run), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
